// File: rtl/fnd_arbiter.sv
// fnd_arbiter: grants one of three sources ownership of the segment display.
// Index 0 has the highest priority. An owner keeps the display for at least
// HOLD_TICKS ticks. After that it can be preempted by a higher-priority source,
// or it is rotated out once another source has waited TIMEOUT_TICKS ticks.
// Optional feature: define FND_BLINK_EN to add the per-source blink input.
// When an owner has its blink bit set, its word alternates with BLANK_WORD
// on successive ticks.
module fnd_arbiter #(
  parameter int unsigned HOLD_TICKS    = 4,
  parameter int unsigned TIMEOUT_TICKS = 16,
  parameter logic [31:0] BLANK_WORD    = 32'h0000_0000
) (
  input  logic        fnd_clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] default_data,
`ifdef FND_BLINK_EN
  input  logic [2:0]  blink,
`endif
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [31:0] fnd_serial
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_W    = 8'(HOLD_TICKS);
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_TICKS);

  state_t      state_r;
  logic [7:0]  hold_cnt_r;
  logic [7:0]  to_cnt_r;
  logic [7:0]  hold_inc_s;
  logic [7:0]  to_inc_s;
  logic        owner_req_s;
  logic [2:0]  others_s;
  logic [2:0]  lower_mask_s;
  logic [2:0]  pick_s;
  logic [31:0] owner_data_s;
  logic [31:0] pick_data_s;
  logic [31:0] shown_data_s;
  logic        do_grant_s;
  logic        go_idle_s;
  logic        go_open_s;
  logic        blank_now_s;
`ifdef FND_BLINK_EN
  logic        phase_r;
  logic        phase_nxt_s;
`endif

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Returns the one-hot of the lowest set bit (highest priority source).
  function automatic logic [2:0] lowest_bit(input logic [2:0] v);
    if (v[0]) begin
      return 3'b001;
    end else if (v[1]) begin
      return 3'b010;
    end else if (v[2]) begin
      return 3'b100;
    end else begin
      return 3'b000;
    end
  endfunction

  // First pending source after the owner in the circular order 0,1,2,0.
  function automatic logic [2:0] rotate_pick(input logic [2:0] owner, input logic [2:0] pend);
    case (owner)
      3'b001: begin
        if (pend[1]) return 3'b010;
        else if (pend[2]) return 3'b100;
        else if (pend[0]) return 3'b001;
        else return 3'b000;
      end
      3'b010: begin
        if (pend[2]) return 3'b100;
        else if (pend[0]) return 3'b001;
        else if (pend[1]) return 3'b010;
        else return 3'b000;
      end
      3'b100: begin
        if (pend[0]) return 3'b001;
        else if (pend[1]) return 3'b010;
        else if (pend[2]) return 3'b100;
        else return 3'b000;
      end
      default: return lowest_bit(pend);
    endcase
  endfunction

  // Selects the display word belonging to a one-hot source.
  function automatic logic [31:0] word_of(input logic [2:0] sel, input logic [31:0] w0,
                                          input logic [31:0] w1, input logic [31:0] w2);
    case (sel)
      3'b001:  return w0;
      3'b010:  return w1;
      3'b100:  return w2;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Decode the owner, the pending set and the source the next grant would go to.
  always_comb begin
    hold_inc_s   = sat_inc(hold_cnt_r);
    to_inc_s     = sat_inc(to_cnt_r);
    owner_req_s  = |(req & gnt);
    others_s     = req & ~gnt;
    lower_mask_s = 3'b000;
    case (gnt)
      3'b010:  lower_mask_s = 3'b001;
      3'b100:  lower_mask_s = 3'b011;
      default: lower_mask_s = 3'b000;
    endcase
    owner_data_s = word_of(gnt, data0, data1, data2);
    // With the owner still requesting, only preemption or rotation can grant.
    if ((state_r == ST_OPEN) && owner_req_s) begin
      if (|(req & lower_mask_s)) begin
        pick_s = lowest_bit(req & lower_mask_s);
      end else begin
        pick_s = rotate_pick(gnt, others_s);
      end
    end else begin
      pick_s = lowest_bit(req);
    end
    pick_data_s = word_of(pick_s, data0, data1, data2);
  end

  // Transition decisions. OPEN rules are checked in order:
  // release first, then preemption, then timeout.
  always_comb begin
    do_grant_s = 1'b0;
    go_idle_s  = 1'b0;
    go_open_s  = 1'b0;
    case (state_r)
      ST_IDLE: do_grant_s = |req;
      ST_LOCK: go_open_s = tick && (hold_inc_s == HOLD_W);
      ST_OPEN: begin
        if (!owner_req_s) begin
          do_grant_s = |req;
          go_idle_s  = ~|req;
        end else if (|(req & lower_mask_s)) begin
          do_grant_s = 1'b1;
        end else begin
          do_grant_s = (|others_s) && tick && (to_inc_s == TIMEOUT_W);
        end
      end
      default: go_idle_s = 1'b1;
    endcase
  end

`ifdef FND_BLINK_EN
  // The blink phase advances on each tick while the display is owned.
  // Blanking uses the new phase, so the word changes on the tick edge itself.
  always_comb begin
    if (busy && tick) begin
      phase_nxt_s = ~phase_r;
    end else begin
      phase_nxt_s = phase_r;
    end
    blank_now_s = phase_nxt_s && (|(blink & gnt));
  end
`else
  // Without blink support the owner's word is never blanked.
  always_comb begin
    blank_now_s = 1'b0;
  end
`endif

  // Word shown for the current owner, after blanking is applied.
  always_comb begin
    shown_data_s = blank_now_s ? BLANK_WORD : owner_data_s;
  end

  // Arbitration FSM. gnt, busy and fnd_serial are registered together with the state.
  always_ff @(posedge fnd_clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      gnt        <= 3'b000;
      busy       <= 1'b0;
      fnd_serial <= 32'h0000_0000;
      hold_cnt_r <= 8'd0;
      to_cnt_r   <= 8'd0;
`ifdef FND_BLINK_EN
      phase_r    <= 1'b0;
`endif
    end else if (do_grant_s) begin
      state_r    <= ST_LOCK;
      gnt        <= pick_s;
      busy       <= 1'b1;
      fnd_serial <= pick_data_s;
      hold_cnt_r <= 8'd0;
      to_cnt_r   <= 8'd0;
`ifdef FND_BLINK_EN
      phase_r    <= 1'b0;
`endif
    end else if (go_idle_s) begin
      state_r    <= ST_IDLE;
      gnt        <= 3'b000;
      busy       <= 1'b0;
      fnd_serial <= default_data;
      hold_cnt_r <= 8'd0;
      to_cnt_r   <= 8'd0;
`ifdef FND_BLINK_EN
      phase_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          fnd_serial <= default_data;
        end
        ST_LOCK: begin
          if (tick) begin
            hold_cnt_r <= hold_inc_s;
          end
          if (go_open_s) begin
            state_r  <= ST_OPEN;
            to_cnt_r <= 8'd0;
          end
          // The word freezes while the owner's request is low.
          if (owner_req_s) begin
            fnd_serial <= shown_data_s;
          end
        end
        ST_OPEN: begin
          // The wait is measured only while someone else is actually waiting.
          if (~|others_s) begin
            to_cnt_r <= 8'd0;
          end else if (tick) begin
            to_cnt_r <= to_inc_s;
          end
          if (owner_req_s) begin
            fnd_serial <= shown_data_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
`ifdef FND_BLINK_EN
      phase_r <= phase_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_fnd_arbiter.sv
// tb_fnd_arbiter: scoreboard bench for fnd_arbiter with the default parameters
// (HOLD_TICKS=4, TIMEOUT_TICKS=16, BLANK_WORD=0).
// The blink scenario is built only when FND_BLINK_EN is defined.
module tb_fnd_arbiter;

  localparam logic [31:0] D0  = 32'hD0D0_0000;
  localparam logic [31:0] D1  = 32'hD1D1_1111;
  localparam logic [31:0] D2  = 32'hD2D2_2222;
  localparam logic [31:0] DEF = 32'h1234_5678;

  typedef struct packed {
    logic [2:0]  gnt;
    logic        busy;
    logic [31:0] ser;
    logic        chk;
  } obs_t;

  logic        fnd_clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [2:0]  req;
  logic [31:0] data0, data1, data2, default_data;
`ifdef FND_BLINK_EN
  logic [2:0]  blink;
`endif
  logic [2:0]  gnt;
  logic        busy;
  logic [31:0] fnd_serial;

  int checks = 0;
  int failures = 0;
  obs_t  exp_q[$];
  obs_t  act_q[$];
  string tag_q[$];

  fnd_arbiter dut (
    .fnd_clk(fnd_clk),
    .rst(rst),
    .tick(tick),
    .req(req),
    .data0(data0),
    .data1(data1),
    .data2(data2),
    .default_data(default_data),
`ifdef FND_BLINK_EN
    .blink(blink),
`endif
    .gnt(gnt),
    .busy(busy),
    .fnd_serial(fnd_serial)
  );

  always #5 fnd_clk = ~fnd_clk;

  // Drive one cycle and queue the expected result. After the edge, capture what the DUT shows.
  task automatic step(input logic t, input logic [2:0] r, input logic [2:0] eg, input logic eb,
                      input logic [31:0] es, input logic ec, input string tag);
    tick = t;
    req  = r;
    exp_q.push_back('{eg, eb, es, ec});
    tag_q.push_back(tag);
    @(posedge fnd_clk);
    #1;
    act_q.push_back('{gnt, busy, fnd_serial, 1'b0});
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge fnd_clk);
    rst  = 1'b0;
    tick = 1'b0;
    req  = 3'b000;
    @(negedge fnd_clk);
    rst = 1'b1;
    @(posedge fnd_clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || fnd_serial !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_immediate: got gnt=%b busy=%b ser=%h, want 000/0/00000000", gnt, busy, fnd_serial);
    end
    repeat (2) @(posedge fnd_clk);
    #1;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || fnd_serial !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_held: got gnt=%b busy=%b ser=%h, want 000/0/00000000", gnt, busy, fnd_serial);
    end
    @(negedge fnd_clk);
    rst = 1'b1;
    req = 3'b000;
    @(posedge fnd_clk);
    #1;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || fnd_serial !== DEF) begin
      failures++;
      $display("FAIL reset_first_edge: got gnt=%b busy=%b ser=%h, want 000/0/%h", gnt, busy, fnd_serial, DEF);
    end
  endtask

  task automatic test_idle();
    obs_t e, a;
    string tg;
    step(1'b0, 3'b000, 3'b000, 1'b0, DEF, 1'b1, "idle_default");
    default_data = 32'hCAFE_F00D;
    step(1'b0, 3'b000, 3'b000, 1'b0, 32'hCAFE_F00D, 1'b1, "idle_follow");
    default_data = DEF;
    step(1'b1, 3'b000, 3'b000, 1'b0, DEF, 1'b1, "idle_tick");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
  endtask

  task automatic test_lock();
    obs_t e, a;
    string tg;
    logic [2:0] r;
    do_reset();
    r = 3'b100;
    step(1'b0, r, 3'b100, 1'b1, 32'h0, 1'b0, "lock_grant");
    for (int t = 1; t <= 4; t++) begin
      step(1'b0, r, 3'b100, 1'b1, D2, 1'b1, "lock_quiet");
      step(1'b0, r, 3'b100, 1'b1, D2, 1'b1, "lock_quiet");
      if (t == 2) r = 3'b101;
      step(1'b1, r, 3'b100, 1'b1, D2, 1'b1, "lock_tick");
    end
    step(1'b0, r, 3'b001, 1'b1, 32'h0, 1'b0, "lock_preempt");
    step(1'b0, r, 3'b001, 1'b1, D0, 1'b1, "lock_new_owner");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, a;
    string tg;
    do_reset();
    step(1'b0, 3'b010, 3'b010, 1'b1, 32'h0, 1'b0, "to_grant");
    for (int t = 1; t <= 4; t++) step(1'b1, 3'b010, 3'b010, 1'b1, D1, 1'b1, "to_hold");
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 3'b110, 3'b010, 1'b1, D1, 1'b1, "to_wait_a");
      step(1'b1, 3'b110, 3'b010, 1'b1, D1, 1'b1, "to_tick_a");
    end
    step(1'b0, 3'b010, 3'b010, 1'b1, D1, 1'b1, "to_clear");
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 3'b110, 3'b010, 1'b1, D1, 1'b1, "to_wait_b");
      if (k == 16) step(1'b1, 3'b110, 3'b100, 1'b1, 32'h0, 1'b0, "to_expire");
      else step(1'b1, 3'b110, 3'b010, 1'b1, D1, 1'b1, "to_tick_b");
    end
    step(1'b0, 3'b110, 3'b100, 1'b1, D2, 1'b1, "to_new_owner");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
  endtask

  task automatic test_release();
    obs_t e, a;
    string tg;
    do_reset();
    step(1'b0, 3'b001, 3'b001, 1'b1, 32'h0, 1'b0, "rel_grant");
    step(1'b0, 3'b001, 3'b001, 1'b1, D0, 1'b1, "rel_lock");
    data0 = 32'h0BAD_0BAD;
    step(1'b0, 3'b000, 3'b001, 1'b1, D0, 1'b1, "rel_freeze");
    step(1'b0, 3'b000, 3'b001, 1'b1, D0, 1'b1, "rel_freeze2");
    data0 = D0;
    for (int t = 1; t <= 4; t++) step(1'b1, 3'b001, 3'b001, 1'b1, D0, 1'b1, "rel_hold");
    step(1'b0, 3'b000, 3'b000, 1'b0, DEF, 1'b1, "rel_idle");
    step(1'b0, 3'b000, 3'b000, 1'b0, DEF, 1'b1, "rel_idle_stay");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    string tg;
    do_reset();
    step(1'b0, 3'b001, 3'b001, 1'b1, 32'h0, 1'b0, "b2b_grant");
    for (int t = 1; t <= 4; t++) step(1'b1, 3'b001, 3'b001, 1'b1, D0, 1'b1, "b2b_hold");
    step(1'b0, 3'b100, 3'b100, 1'b1, 32'h0, 1'b0, "b2b_handoff");
    step(1'b0, 3'b100, 3'b100, 1'b1, D2, 1'b1, "b2b_owner2");
    step(1'b0, 3'b000, 3'b100, 1'b1, D2, 1'b1, "b2b_lock_keep");
    step(1'b0, 3'b011, 3'b100, 1'b1, D2, 1'b1, "b2b_no_preempt");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, a;
    string tg;
    do_reset();
    step(1'b0, 3'b010, 3'b010, 1'b1, 32'h0, 1'b0, "ar_grant");
    for (int t = 1; t <= 4; t++) step(1'b1, 3'b010, 3'b010, 1'b1, D1, 1'b1, "ar_hold");
    step(1'b0, 3'b110, 3'b010, 1'b1, D1, 1'b1, "ar_open");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || fnd_serial !== 32'h0000_0000) begin
      failures++;
      $display("FAIL ar_immediate: got gnt=%b busy=%b ser=%h, want 000/0/00000000", gnt, busy, fnd_serial);
    end
    @(negedge fnd_clk);
    rst = 1'b1;
    req = 3'b000;
    @(posedge fnd_clk);
    #1;
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || fnd_serial !== DEF) begin
      failures++;
      $display("FAIL ar_first_edge: got gnt=%b busy=%b ser=%h, want 000/0/%h", gnt, busy, fnd_serial, DEF);
    end
  endtask

`ifdef FND_BLINK_EN
  task automatic test_blink();
    obs_t e, a;
    string tg;
    logic [31:0] w;
    do_reset();
    blink = 3'b001;
    data0 = 32'hAAAA_AAAA;
    step(1'b0, 3'b001, 3'b001, 1'b1, 32'h0, 1'b0, "blink_grant");
    step(1'b0, 3'b001, 3'b001, 1'b1, 32'hAAAA_AAAA, 1'b1, "blink_phase0");
    for (int k = 1; k <= 6; k++) begin
      w = (k % 2 == 1) ? 32'h0000_0000 : 32'hAAAA_AAAA;
      step(1'b1, 3'b001, 3'b001, 1'b1, w, 1'b1, "blink_tick");
      step(1'b0, 3'b001, 3'b001, 1'b1, w, 1'b1, "blink_steady");
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tg = tag_q.pop_front();
      checks++;
      if (a.gnt !== e.gnt || a.busy !== e.busy || (e.chk && a.ser !== e.ser)) begin
        failures++;
        $display("FAIL %s: got gnt=%b busy=%b ser=%h, want gnt=%b busy=%b ser=%h", tg, a.gnt, a.busy, a.ser, e.gnt, e.busy, e.ser);
      end
    end
    blink = 3'b000;
    data0 = D0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    req = 3'b001;
    data0 = D0;
    data1 = D1;
    data2 = D2;
    default_data = DEF;
`ifdef FND_BLINK_EN
    blink = 3'b000;
`endif
    test_reset();
    test_idle();
    test_lock();
    test_timeout();
    test_release();
    test_back_to_back();
    test_async_reset();
`ifdef FND_BLINK_EN
    test_blink();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_arbiter.md
FND_ARBITER -- requirements
Module: fnd_arbiter

Interface
REQ-001 Parameter HOLD_TICKS, default 4, minimum ticks an owner keeps the display after grant (legal range 1..255).
REQ-002 Parameter TIMEOUT_TICKS, default 16, maximum ticks an owner keeps the display while another requester waits (legal range 1..255).
REQ-003 Parameter BLANK_WORD, default 32'h0000_0000, word driven during the blink-off phase.
REQ-004 fnd_clk  input  1  clock; reset rst, asynchronous, active-low.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 tick  input  1  one-cycle time-base strobe, synchronous to fnd_clk.
REQ-007 req  input  3  request per source; index 0 is highest priority.
REQ-008 data0, data1, data2  input  32 each  display word per source.
REQ-009 default_data  input  32  word shown when no source owns the display.
REQ-010 gnt  output  3  registered one-hot grant, all-zero when idle.
REQ-011 busy  output  1  high when any source owns the display.
REQ-012 fnd_serial  output  32  registered word to the segment driver.

Function
REQ-013 States IDLE, LOCK and OPEN shall exist; gnt, busy and fnd_serial shall update on the same fnd_clk edge as the state.
REQ-014 IDLE: fnd_serial shall load default_data every cycle; on any req, the next edge shall grant the lowest set index, enter LOCK and clear hold_cnt.
REQ-015 LOCK: fnd_serial shall load the owner's data every cycle while the owner's req is high, and freeze at the last loaded value while it is low; no preemption.
REQ-016 LOCK: hold_cnt shall increment on tick; the tick making hold_cnt equal HOLD_TICKS shall move to OPEN on that edge and clear to_cnt.
REQ-017 OPEN, priority 1: owner req low shall grant the lowest pending index and enter LOCK, else enter IDLE (one-cycle latency, fnd_serial = default_data on the IDLE-entry edge).
REQ-018 OPEN, priority 2: a pending lower index than the owner shall preempt: grant it and enter LOCK.
REQ-019 OPEN, priority 3: to_cnt shall increment on tick while any other req is high and clear when none is; the tick making to_cnt equal TIMEOUT_TICKS shall grant the first pending index after the owner in order 0,1,2,0 and enter LOCK.
REQ-020 Rules in REQ-017..019 shall be evaluated in the stated priority order within one cycle; a tick coinciding with a transition shall count in the old state only.
REQ-021 Counters shall be 8 bits and shall saturate, never wrap.
REQ-022 gnt shall never have more than one bit set; busy shall equal OR of gnt.

Reset
REQ-023 rst low shall immediately force state IDLE, gnt=3'b000, busy=0, fnd_serial=32'h0000_0000, hold_cnt=0, to_cnt=0 and blink phase=0, including mid-LOCK or mid-OPEN.
REQ-024 After rst release, the first fnd_clk edge shall behave as IDLE.

Configuration
REQ-025 With macro FND_BLINK_EN defined, input blink (3 bits, one per source) shall exist, and a phase bit shall toggle on every tick while busy.
REQ-026 With FND_BLINK_EN defined and the owner's blink bit high, fnd_serial shall load BLANK_WORD when the phase is 1; phase shall clear on every grant.
REQ-027 Without FND_BLINK_EN, the blink port and phase logic shall not exist and data shall pass unmodified.

Verification
REQ-028 Idle: req=0, default_data=32'h1234_5678 -> fnd_serial=32'h1234_5678 one edge later, gnt=0, busy=0.
REQ-029 Lock: req=3'b100, then req[0] rises at tick 2 -> gnt stays 3'b100 until the 4th tick, then 3'b001 next edge.
REQ-030 Timeout: owner 1 in OPEN, req[2] held -> gnt=3'b100 on the edge of the 16th tick.
REQ-031 Release: owner drops req in OPEN with nothing pending -> IDLE next edge, fnd_serial=default_data.
REQ-032 Reset: rst low mid-OPEN -> outputs at reset values immediately, without an fnd_clk edge.
REQ-033 Blink: FND_BLINK_EN defined, blink=3'b001, owner 0, data0=32'hAAAA_AAAA -> fnd_serial alternates 32'hAAAA_AAAA / BLANK_WORD on successive ticks.
